// File: rtl/elastic_pipeline_stage.sv
// elastic_pipeline_stage: valid/ready register stage with 2-entry skid buffer.
// Optional stall counter enabled by defining PIPELINE_STALL_COUNT_EN.
module elastic_pipeline_stage #(
    parameter int Width = 23
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nx;
    logic [Width-1:0] main_q, skid_q;
    logic in_fire, out_fire, load_main, load_skid;
    // handshake outputs depend on state only, so out_ready never reaches in_ready
    always_comb begin
        in_ready  = state != FULL;
        out_valid = state != EMPTY;
        occupancy = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        load_main = in_fire & (state == EMPTY | out_fire);
        load_skid = state == ONE & in_fire & ~out_fire;
        state_nx  = state;
        if (flush)
            state_nx = EMPTY;
        else if (state == EMPTY)
            state_nx = in_fire ? ONE : EMPTY;
        else if (state == ONE)
            state_nx = in_fire & ~out_fire ? FULL : ~in_fire & out_fire ? EMPTY : ONE;
        else
            state_nx = out_fire ? ONE : FULL;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            if (load_main)
                main_q <= in_data;
            else if (state == FULL & out_fire)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_data;
        end
    end
    assign out_data = main_q;
`ifdef PIPELINE_STALL_COUNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_q <= '0;
        else if (flush)
            stall_q <= '0;
        else if (out_valid & ~out_ready & stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_elastic_pipeline_stage.sv
// tb_elastic_pipeline_stage: queue-model checker plus directed and random traffic.
module tb_elastic_pipeline_stage;
    localparam int W = 23;
    logic clock = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0] occupancy;
    logic [15:0] stall_count;
    int tests = 0, fails = 0;
    logic [W-1:0] mq[$], got[$], words[20];
    int ms = 0;
    bit m_in, m_out;

    always #5 clock = ~clock;

    elastic_pipeline_stage #(.Width(W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [15:0] exp_stall(input int s);
`ifdef PIPELINE_STALL_COUNT_EN
        return s[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // FIFO of words the stage must hold, advanced by the handshake rules
    always @(posedge clock) begin
        if (reset) begin
            m_in  = in_valid && mq.size() < 2;
            m_out = mq.size() > 0 && out_ready;
            if (out_valid && out_ready) got.push_back(out_data);
            if (flush) ms = 0;
            else if (mq.size() > 0 && !out_ready && ms < 16'hFFFF) ms++;
            if (m_out) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (m_in) mq.push_back(in_data);
        end
    end

    always @(negedge reset) begin
        mq.delete();
        ms = 0;
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("in_ready", in_ready, mq.size() < 2);
            chk("out_valid", out_valid, mq.size() > 0);
            chk("occupancy", occupancy, mq.size());
            chk("stall_count", stall_count, exp_stall(ms));
            if (mq.size() > 0) chk("out_data", out_data, mq[0]);
        end
    end

    initial begin
        int sent;
        bit acc;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_count, 0);
        #11 reset = 1;
        // streaming at full rate
        out_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1;
            in_data = W'(i);
            cyc();
            chk("t1_occ", occupancy, 1);
            chk("t1_out_data", out_data, i);
        end
        in_valid = 0;
        repeat (3) cyc();
        chk("t1_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t1_word", got[i], i + 1);
        got.delete();
        // skid fill and backpressure
        in_valid = 1; in_data = 23'h0ABCDE; out_ready = 1;
        cyc();
        out_ready = 0; in_data = 23'h012345;
        cyc();
        chk("t2_occ", occupancy, 2);
        chk("t2_in_ready", in_ready, 0);
        in_data = 23'h7FFFFF;
        repeat (2) cyc();
        in_valid = 0; out_ready = 1;
        repeat (4) cyc();
        chk("t2_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_first", got[0], 23'h0ABCDE);
            chk("t2_second", got[1], 23'h012345);
        end
        got.delete();
        // stall counter
        flush = 1; cyc(); flush = 0;
        in_valid = 1; in_data = 23'h000123; out_ready = 0;
        cyc();
        in_valid = 0;
        repeat (7) cyc();
        chk("stall_7", stall_count, exp_stall(7));
        flush = 1; cyc(); flush = 0;
        chk("stall_flush", stall_count, 0);
        chk("stall_flush_occ", occupancy, 0);
        // alternating out_ready over 20 words
        for (int i = 0; i < 20; i++) words[i] = W'($urandom);
        sent = 0;
        out_ready = 0;
        for (int k = 0; k < 200 && sent < 20; k++) begin
            in_valid = 1;
            in_data = words[sent];
            out_ready = ~out_ready;
            acc = in_ready;
            cyc();
            if (acc) sent++;
        end
        chk("t3_sent", sent, 20);
        in_valid = 0; out_ready = 1;
        repeat (5) cyc();
        chk("t3_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk("t3_word", got[i], words[i]);
        got.delete();
        // flush from FULL with a simultaneous in_valid
        out_ready = 0; in_valid = 1; in_data = 23'h000AAA;
        cyc();
        in_data = 23'h000BBB;
        cyc();
        chk("t4_full", occupancy, 2);
        flush = 1; in_data = 23'h000CCC;
        cyc();
        flush = 0; in_valid = 0;
        chk("t4_occ", occupancy, 0);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        out_ready = 1;
        repeat (3) cyc();
        chk("t4_none", got.size(), 0);
        // asynchronous reset while holding two words
        out_ready = 0; in_valid = 1; in_data = 23'h000111;
        cyc();
        in_data = 23'h000222;
        cyc();
        in_valid = 0;
        #2 reset = 0;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_occ", occupancy, 0);
        #2 reset = 1;
        // random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            in_data = W'($urandom);
            cyc();
        end
        flush = 0; in_valid = 0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/elastic_pipeline_stage.md
Name: elastic_pipeline_stage

Overview:
Pipeline register with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Upstream side accepts data; downstream side delivers it, with full backpressure support.
- Placed between arithmetic pipeline stages (mantissa/exponent paths) where a downstream stage can stall.
- Sustains one transfer per cycle with no combinational path from out_ready to in_ready.

Parameters:
Width, 23, data word width in bits.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
flush  input  1  synchronous clear of all held data, active-high.
in_valid  input  1  upstream presents a word on in_data.
in_ready  output  1  stage can accept a word this cycle.
in_data  input  Width  upstream data word.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  Width  downstream data word.
occupancy  output  2  words currently held: 0, 1 or 2.
stall_count  output  16  cycles with out_valid=1 and out_ready=0 (see Optional Feature).

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- State machine, states EMPTY / ONE / FULL:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire & out_fire -> ONE, main <= in_data.
  - ONE, in_fire & !out_fire -> FULL, skid <= in_data.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE.
  - FULL: in_fire impossible because in_ready=0. out_fire -> ONE, main <= skid. Otherwise hold.
- Outputs are registered, derived from state only:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - occupancy = 0 / 1 / 2 for EMPTY / ONE / FULL.
- Latency: a word accepted on edge N appears on out_data with out_valid=1 after edge N (one cycle).
- Throughput: 1 word/cycle when out_ready stays high.
- Ordering: strict FIFO. Skid contents always go out after main. No word is dropped or duplicated.
- out_data while out_valid=0: holds its last value. Value is don't-care for checkers.
- flush:
  - Forces the EMPTY state on the next edge and overrides any simultaneous in_fire/out_fire.
  - The out_fire that occurs in the flush cycle counts as delivered. The in_fire in the flush cycle is discarded.
  - Data registers are not required to clear.
- Reset (reset=0), immediate and asynchronous:
  - state=EMPTY, in_ready=1, out_valid=0, occupancy=0.
  - main=0, skid=0, out_data=0, stall_count=0.
  - Reset mid-transfer discards all held words.
- Upstream may change in_data while in_valid=1 & in_ready=0. The stage samples only on in_fire.
- Downstream rule: out_data and out_valid stay stable until out_fire.

Optional Feature:
Macro PIPELINE_STALL_COUNT_EN.
- Defined: stall_count increments by 1 on each edge where out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by flush.
- Undefined: no counter logic; stall_count is tied to 0.

Test Plan:
- Reset, then drive 0x000001..0x000005 on consecutive cycles with out_ready=1 -> out_data is 1..5 on consecutive cycles, starting one cycle after the first accept; occupancy stays 1; in_ready stays 1.
- Accept 0x0ABCDE, drop out_ready, send 0x012345 -> occupancy=2, in_ready=0; in_data=0x7FFFFF presented while in_ready=0 is ignored; raise out_ready -> outputs 0x0ABCDE then 0x012345 only.
- Alternate out_ready 1/0 each cycle with in_valid held high for 20 words -> all 20 delivered in order; no loss or duplicate; occupancy never exceeds 2.
- FULL state, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1; the word presented with flush never appears.
- Hold two words, pull reset low mid-cycle -> out_valid=0, out_data=0, in_ready=1 immediately, before the next clock edge.
- With PIPELINE_STALL_COUNT_EN: out_valid=1 and out_ready=0 for 7 cycles -> stall_count=7; flush -> 0; without the macro, stall_count stays 0 throughout.
